// File: rtl/pipe_seq_pkg.sv
// Shared types and encodings for the pipeline sequencer (pipe_seq_ctrl).
package pipe_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST        = 3'd0,
    ST_RUN        = 3'd1,
    ST_MEM_WAIT   = 3'd2,
    ST_TRAP_FLUSH = 3'd3,
    ST_TRAP_VEC   = 3'd4
  } state_t;

  // PC mux select encodings
  localparam logic [1:0] PC_SRC_BOOT   = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP   = 2'b10;
  localparam logic [1:0] PC_SRC_SEQ    = 2'b11;

  // Trap cause codes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_IRQ     = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with zero flag. Reset value is the reset-hold
// preload so the hold starts counting the moment reset is released.
module seq_timer #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: flush/stall/PC-source control for IF/ID with reset
// hold, redirects, load-use stalls, memory wait with timeout trap, and
// interrupt/mret handling.
// Optional interrupt path: define PIPE_SEQ_IRQ_EN to enable it.
//
// Handshake: none; all event inputs are level flags sampled every cycle.
// In RUN the control outputs are a same-cycle function of the inputs;
// trap_taken_out, irq_ack_out and cause_out are registered.
module pipe_seq_ctrl
  import pipe_seq_pkg::*;
#(
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT      = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       branch_taken_in,
  input  logic       jump_in,
  input  logic       load_use_in,
  input  logic       dmem_req_in,
  input  logic       dmem_ready_in,
  input  logic       irq_in,
  input  logic       mret_in,
  output logic       flush_out,
  output logic       stall_out,
  output logic [1:0] pc_src_out,
  output logic       vec_sel_out,
  output logic       trap_taken_out,
  output logic       irq_ack_out,
  output logic [1:0] cause_out,
  output state_t     state_out
);

  localparam int TW = $clog2(max2(RST_FLUSH_CYCLES, MEM_TIMEOUT));
  localparam logic [TW-1:0] RST_LOAD = TW'(RST_FLUSH_CYCLES - 1);
  localparam logic [TW-1:0] MEM_LOAD = TW'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [1:0] cause_q;
  logic       trap_taken_q;
  logic       irq_ack_q;
  logic       timer_load;
  logic       timer_dec;
  logic       timer_zero;
  logic       irq_sel;

`ifdef PIPE_SEQ_IRQ_EN
  assign irq_sel     = irq_in;
  assign irq_ack_out = irq_ack_q;
`else
  logic unused_irq;
  logic unused_ack;
  assign unused_irq  = irq_in;
  assign unused_ack  = irq_ack_q;
  assign irq_sel     = 1'b0;
  assign irq_ack_out = 1'b0;
`endif

  seq_timer #(
    .W       (TW),
    .RST_VAL (RST_LOAD)
  ) u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (timer_load),
    .load_val (MEM_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Next-state and same-cycle control decode; RUN events in priority order.
  always_comb begin
    next_state  = state;
    flush_out   = 1'b0;
    stall_out   = 1'b0;
    pc_src_out  = PC_SRC_SEQ;
    vec_sel_out = 1'b0;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    case (state)
      ST_RST: begin
        flush_out  = 1'b1;
        pc_src_out = PC_SRC_BOOT;
        timer_dec  = 1'b1;
        if (timer_zero) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_req_in && !dmem_ready_in) begin
          stall_out  = 1'b1;
          timer_load = 1'b1;
          next_state = ST_MEM_WAIT;
        end else if (irq_sel) begin
          flush_out  = 1'b1;
          next_state = ST_TRAP_FLUSH;
        end else if (mret_in) begin
          flush_out   = 1'b1;
          pc_src_out  = PC_SRC_TRAP;
          vec_sel_out = 1'b1;
        end else if (branch_taken_in || jump_in) begin
          flush_out  = 1'b1;
          pc_src_out = PC_SRC_TARGET;
        end else if (load_use_in) begin
          stall_out = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        stall_out = 1'b1;
        timer_dec = 1'b1;
        if (dmem_ready_in)   next_state = ST_RUN;
        else if (timer_zero) next_state = ST_TRAP_FLUSH;
      end
      ST_TRAP_FLUSH: begin
        flush_out  = 1'b1;
        next_state = ST_TRAP_VEC;
      end
      ST_TRAP_VEC: begin
        flush_out  = 1'b1;
        pc_src_out = PC_SRC_TRAP;
        next_state = ST_RUN;
      end
      default: begin
        flush_out  = 1'b1;
        pc_src_out = PC_SRC_BOOT;
        next_state = ST_RST;
      end
    endcase
  end

  // State register plus registered trap pulses and sticky cause.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= ST_RST;
      cause_q      <= CAUSE_NONE;
      trap_taken_q <= 1'b0;
      irq_ack_q    <= 1'b0;
    end else begin
      state        <= next_state;
      trap_taken_q <= (state == ST_TRAP_FLUSH);
      irq_ack_q    <= (state == ST_TRAP_FLUSH) && (cause_q == CAUSE_IRQ);
      if ((state == ST_RUN) && (next_state == ST_TRAP_FLUSH)) begin
        cause_q <= CAUSE_IRQ;
      end else if ((state == ST_MEM_WAIT) && (next_state == ST_TRAP_FLUSH)) begin
        cause_q <= CAUSE_TIMEOUT;
      end
    end
  end

  assign trap_taken_out = trap_taken_q;
  assign cause_out      = cause_q;
  assign state_out      = state;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: directed scenarios followed by
// randomized traffic, checked cycle by cycle against a reference model.
module tb_pipe_seq_ctrl;
  import pipe_seq_pkg::*;

  localparam int RSTC = 2;
  localparam int MTO  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       br, jmp, lu, req, rdy, irq, mret;
  logic       flush, stall, vec_sel, trap_taken, irq_ack;
  logic [1:0] pc_src, cause;
  state_t     state_dbg;

  pipe_seq_ctrl #(
    .RST_FLUSH_CYCLES (RSTC),
    .MEM_TIMEOUT      (MTO)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .branch_taken_in (br),
    .jump_in         (jmp),
    .load_use_in     (lu),
    .dmem_req_in     (req),
    .dmem_ready_in   (rdy),
    .irq_in          (irq),
    .mret_in         (mret),
    .flush_out       (flush),
    .stall_out       (stall),
    .pc_src_out      (pc_src),
    .vec_sel_out     (vec_sel),
    .trap_taken_out  (trap_taken),
    .irq_ack_out     (irq_ack),
    .cause_out       (cause),
    .state_out       (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  // {flush, stall, pc_src[1:0], vec_sel, trap_taken, irq_ack, cause[1:0]}
  logic [8:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // rst_left: reset-hold flush cycles still owed; wait_n: MEM_WAIT cycles
  // already spent (-1 = not waiting); trap_stage: 0 none, 1 flush, 2 vector.
  int         m_rst_left;
  int         m_wait_n;
  int         m_trap_stage;
  logic [1:0] m_cause;

  task automatic model_reset();
    m_rst_left   = RSTC;
    m_wait_n     = -1;
    m_trap_stage = 0;
    m_cause      = 2'b00;
  endtask

  task automatic model_step();
    logic f, s, v, tt, ak, irq_eff;
    logic [1:0] pc, c;
    f = 1'b0; s = 1'b0; v = 1'b0; tt = 1'b0; ak = 1'b0;
    pc = 2'b11;
    c  = m_cause;
`ifdef PIPE_SEQ_IRQ_EN
    irq_eff = irq;
`else
    irq_eff = 1'b0;
`endif
    if (m_rst_left > 0) begin
      f = 1'b1; pc = 2'b00;
      m_rst_left--;
    end else if (m_trap_stage == 1) begin
      f = 1'b1;
      m_trap_stage = 2;
    end else if (m_trap_stage == 2) begin
      f = 1'b1; pc = 2'b10; tt = 1'b1;
      ak = (m_cause == 2'b01);
      m_trap_stage = 0;
    end else if (m_wait_n >= 0) begin
      s = 1'b1;
      if (rdy) begin
        m_wait_n = -1;
      end else if (m_wait_n == MTO - 1) begin
        m_wait_n = -1;
        m_trap_stage = 1;
        m_cause = 2'b10;
      end else begin
        m_wait_n++;
      end
    end else if (req && !rdy) begin
      s = 1'b1;
      m_wait_n = 0;
    end else if (irq_eff) begin
      f = 1'b1;
      m_trap_stage = 1;
      m_cause = 2'b01;
    end else if (mret) begin
      f = 1'b1; pc = 2'b10; v = 1'b1;
    end else if (br || jmp) begin
      f = 1'b1; pc = 2'b01;
    end else if (lu) begin
      s = 1'b1;
    end
    exp_q.push_back({f, s, pc, v, tt, ak, c});
  endtask

  task automatic compare_outputs();
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 4'd1, 4'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("flush",      {3'b0, flush},      {3'b0, e[8]});
      check_eq("stall",      {3'b0, stall},      {3'b0, e[7]});
      check_eq("pc_src",     {2'b0, pc_src},     {2'b0, e[6:5]});
      check_eq("vec_sel",    {3'b0, vec_sel},    {3'b0, e[4]});
      check_eq("trap_taken", {3'b0, trap_taken}, {3'b0, e[3]});
      check_eq("irq_ack",    {3'b0, irq_ack},    {3'b0, e[2]});
      check_eq("cause",      {2'b0, cause},      {2'b0, e[1:0]});
    end
  endtask

  task automatic check_reset_values();
    check_eq("rst_flush",      {3'b0, flush},      4'd1);
    check_eq("rst_stall",      {3'b0, stall},      4'd0);
    check_eq("rst_pc_src",     {2'b0, pc_src},     4'd0);
    check_eq("rst_vec_sel",    {3'b0, vec_sel},    4'd0);
    check_eq("rst_trap_taken", {3'b0, trap_taken}, 4'd0);
    check_eq("rst_irq_ack",    {3'b0, irq_ack},    4'd0);
    check_eq("rst_cause",      {2'b0, cause},      4'd0);
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives one cycle, checks at the falling edge.
  task automatic drive_cycle(input logic b, input logic j, input logic l,
                             input logic rq, input logic rd, input logic ir,
                             input logic mr);
    br = b; jmp = j; lu = l; req = rq; rdy = rd; irq = ir; mret = mr;
    @(negedge clk);
    model_step();
    compare_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges, check values before the next edge, release.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_reset_values();
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    br = 0; jmp = 0; lu = 0; req = 0; rdy = 0; irq = 0; mret = 0;
    #3 check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    idle(4);                                  // reset hold then RUN
    drive_cycle(1, 0, 0, 0, 0, 0, 0);         // branch redirect
    idle(2);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 1, 0, 0);         // ready after 3 low cycles
    idle(2);
    for (int i = 0; i < MTO + 1; i++) drive_cycle(0, 0, 0, 1, 0, 0, 0);
    idle(4);                                  // timeout trap flush/vector
    drive_cycle(1, 0, 0, 0, 0, 1, 0);         // irq with branch
    idle(4);
    drive_cycle(0, 0, 0, 0, 0, 0, 1);         // mret
    drive_cycle(0, 1, 0, 0, 0, 0, 0);         // jump
    drive_cycle(0, 0, 1, 0, 0, 0, 0);         // load-use
    drive_cycle(0, 1, 1, 0, 0, 0, 1);         // mret beats jump and load-use
    idle(1);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 1, 0, 0, 0);
    async_reset();                            // reset mid MEM_WAIT
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        drive_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 11) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
# pipe_seq_ctrl

Pipeline sequencer for the STRV32I core: replaces the two-state boot controller with a full control FSM that generates `flush_out`, `stall_out` and `pc_src_out` for the fetch/decode stages. It also handles:
- reset flush hold;
- branch/jump redirects;
- load-use bubbles;
- data-memory wait states with timeout;
- interrupt/trap entry and `mret` return.

It sits beside the datapath, consuming hazard and event flags from EX/MEM and driving the PC mux and the pipeline-register control inputs.

## Interface
Parameters:
- RST_FLUSH_CYCLES, 2, cycles flush is held after reset release (≥1)
- MEM_TIMEOUT, 16, MEM_WAIT cycles before bus-timeout trap (≥2)

Ports:
- clk_in  in  1  single clock, rising edge
- rst_in  in  1  asynchronous, active-high reset
- branch_taken_in  in  1  EX: branch resolved taken
- jump_in  in  1  EX: jal/jalr
- load_use_in  in  1  ID: load-use hazard detected
- dmem_req_in  in  1  MEM: access in progress
- dmem_ready_in  in  1  MEM: data memory ready
- irq_in  in  1  level interrupt request
- mret_in  in  1  EX: mret executing
- flush_out  out  1  clear IF/ID and ID/EX
- stall_out  out  1  hold PC and IF/ID
- pc_src_out  out  2  00 boot addr, 01 branch/jump target, 10 trap vector/mepc, 11 PC+4
- vec_sel_out  out  1  with pc_src 10: 0 = mtvec, 1 = mepc
- trap_taken_out  out  1  one-cycle pulse on trap vectoring
- irq_ack_out  out  1  one-cycle pulse, interrupt accepted
- cause_out  out  2  registered: 00 none, 01 irq, 10 bus timeout

## Operation
- States: RST, RUN, MEM_WAIT, TRAP_FLUSH, TRAP_VEC.
- RST:
  - flush=1, stall=0, pc_src=00.
  - Counter loads RST_FLUSH_CYCLES-1 and decrements; at 0, go to RUN.
- RUN, same-cycle (Mealy) decisions, highest priority first:
  1. `dmem_req_in & !dmem_ready_in`: stall=1; go to MEM_WAIT; counter loads MEM_TIMEOUT-1.
  2. `irq_in`: flush=1; go to TRAP_FLUSH; cause register ← 01.
  3. `mret_in`: flush=1, pc_src=10, vec_sel=1.
  4. `branch_taken_in | jump_in`: flush=1, pc_src=01.
  5. `load_use_in`: stall=1, flush=0, pc_src=11. ID/EX bubble is handled by the datapath from stall.
  6. Otherwise: flush=0, stall=0, pc_src=11.
- MEM_WAIT:
  - stall=1, pc_src=11; counter decrements.
  - `dmem_ready_in` → RUN. This wins over timeout in the same cycle.
  - Counter at 0 with ready low → TRAP_FLUSH; cause ← 10.
- TRAP_FLUSH: flush=1, stall=0, pc_src=11; unconditionally → TRAP_VEC.
- TRAP_VEC:
  - flush=1, pc_src=10, vec_sel=0, trap_taken_out=1.
  - irq_ack_out=1 iff cause=01.
  - → RUN.
- A lower-priority event coincident with a higher one is dropped. The flush discards the instruction carrying it, and it re-issues after the redirect.
- `irq_in` is ignored outside RUN. It is sampled again on the first RUN cycle.
- cause_out holds its value until the next trap.

## Timing
- Reset (async assert), all outputs: state=RST, flush_out=1, stall_out=0, pc_src_out=00, vec_sel_out=0, trap_taken_out=0, irq_ack_out=0, cause_out=00.
- Reset release: flush held exactly RST_FLUSH_CYCLES rising edges. First RUN cycle has pc_src=11.
- Redirect/mret:
  - zero-latency, combinational from inputs in RUN;
  - exactly one flush cycle per asserted event cycle.
- Trap entry: irq seen in cycle N → flush in N, N+1, N+2; vector pc_src=10 in N+2; RUN in N+3.
- Timeout: ready low for MEM_TIMEOUT consecutive MEM_WAIT cycles → TRAP_FLUSH next cycle.
- Reset asserted mid-operation: immediate return to RST. No pulse outputs survive.

## Configuration
- PIPE_SEQ_IRQ_EN defined: interrupt path present as above.
- Undefined:
  - irq_in is unused;
  - irq_ack_out is tied 0;
  - cause 01 never occurs;
  - TRAP_FLUSH is reachable only via bus timeout.

## Structure
- Package pipe_seq_pkg holds:
  - state enum;
  - PC_SRC_BOOT/TARGET/TRAP/SEQ encodings;
  - CAUSE_NONE/IRQ/TIMEOUT codes.
- Sub-module seq_timer: loadable down-counter with zero flag, shared by the reset hold and MEM_WAIT timeout. Width is $clog2 of the larger parameter.

## Test plan
- Reset released with defaults → flush=1, pc_src=00 for 2 cycles, then flush=0, pc_src=11.
- RUN, branch_taken_in pulse 1 cycle → same cycle flush=1, pc_src=01; next cycle pc_src=11.
- dmem_req_in=1, ready low 3 cycles then high → stall=1 for 4 cycles, no trap, cause_out=00.
- Ready held low 16 MEM_WAIT cycles → TRAP_VEC with pc_src=10, vec_sel=0, trap_taken=1, cause_out=10, irq_ack=0.
- irq_in and branch_taken_in together in RUN → irq wins: flush for 3 cycles, irq_ack pulse in TRAP_VEC, cause_out=01. Without PIPE_SEQ_IRQ_EN → branch redirect only.
- rst_in asserted mid-MEM_WAIT, asynchronously between edges → outputs reach reset values before the next edge.
